// File: rtl/clk_run_pkg.sv
// Shared encodings for the processor run-control sequencer.
// Holds the mode codes and sequencer states used across the slice.
package clk_run_pkg;

    localparam logic [1:0] MODE_HALT  = 2'b00;
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STEP_PEND,
        BURST,
        DONE,
        HALTED
    } state_t;

    function automatic logic is_active(state_t s);
        return (s == RUN) || (s == STEP_PEND) || (s == BURST);
    endfunction

endpackage

// File: rtl/clk_run_ctrl_if.sv
// Operator controls in, CPU clock-enable status out.
// master drives the controls, slave is the sequencer.
interface clk_run_ctrl_if #(
    parameter int DIV_W   = 32,
    parameter int BURST_W = 16,
    parameter int CNT_W   = 32
);
    logic [1:0]         iMode;
    logic               iStep;
    logic [DIV_W-1:0]   iDiv;
    logic [BURST_W-1:0] iBurstLen;
    logic               iHalt;
    logic               oClkEn;
    logic               oBusy;
    logic               oHalted;
    logic [CNT_W-1:0]   oPulseCnt;

    modport master (
        output iMode, iStep, iDiv, iBurstLen, iHalt,
        input  oClkEn, oBusy, oHalted, oPulseCnt
    );

    modport slave (
        input  iMode, iStep, iDiv, iBurstLen, iHalt,
        output oClkEn, oBusy, oHalted, oPulseCnt
    );

endinterface

// File: rtl/tick_gen.sv
// Programmable divider producing a one-cycle tick every div cycles.
// A divisor of 0 behaves as 1; lowering it below the count ticks at once.
module tick_gen #(
    parameter int DIV_W = 32
) (
    input  logic             iClk,
    input  logic             nRst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] lim;

    assign div_eff = (div == '0) ? DIV_W'(1) : div;
    assign lim     = div_eff - DIV_W'(1);
    assign tick    = en && (cnt >= lim);

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            cnt <= '0;
        end else if (clr || !en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/clk_run_ctrl.sv
// Run-control sequencer gating divided ticks into CPU clock-enable pulses.
// Define CLK_RUN_CTRL_SYNC_EN to double-flop iStep and iHalt on entry.
module clk_run_ctrl
    import clk_run_pkg::*;
#(
    parameter int DIV_W   = 32,
    parameter int BURST_W = 16,
    parameter int CNT_W   = 32
) (
    input logic          iClk,
    input logic          nRst,
    clk_run_ctrl_if.slave bus
);

    state_t             st;
    state_t             st_nx;
    logic               step_s;
    logic               halt_s;
    logic               step_q;
    logic               step_edge;
    logic               active;
    logic               stay;
    logic               tick;
    logic               accept;
    logic               load;
    logic               clk_en;
    logic [BURST_W-1:0] rem;
    logic [CNT_W-1:0]   pcnt;

`ifdef CLK_RUN_CTRL_SYNC_EN
    logic [1:0] step_sy;
    logic [1:0] halt_sy;

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            step_sy <= '0;
            halt_sy <= '0;
        end else begin
            step_sy <= {step_sy[0], bus.iStep};
            halt_sy <= {halt_sy[0], bus.iHalt};
        end
    end

    assign step_s = step_sy[1];
    assign halt_s = halt_sy[1];
`else
    assign step_s = bus.iStep;
    assign halt_s = bus.iHalt;
`endif

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step_s;
        end
    end

    assign step_edge = step_s & ~step_q;
    assign active    = is_active(st);

    // An active state survives only while the operator keeps its mode.
    assign stay = ((st == RUN)       && (bus.iMode == MODE_RUN))  ||
                  ((st == STEP_PEND) && (bus.iMode == MODE_STEP)) ||
                  ((st == BURST)     && (bus.iMode == MODE_BURST));

    tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick (
        .iClk (iClk),
        .nRst (nRst),
        .en   (active),
        .clr  (st_nx != st),
        .div  (bus.iDiv),
        .tick (tick)
    );

    always_comb begin
        st_nx  = st;
        accept = 1'b0;
        load   = 1'b0;
        unique case (st)
            IDLE: begin
                unique case (1'b1)
                    (bus.iMode == MODE_RUN): st_nx = RUN;
                    (bus.iMode == MODE_STEP) && step_edge:
                        st_nx = STEP_PEND;
                    (bus.iMode == MODE_BURST): begin
                        if (bus.iBurstLen == '0) begin
                            st_nx = DONE;
                        end else begin
                            st_nx = BURST;
                            load  = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            RUN, STEP_PEND, BURST: begin
                if (halt_s) begin
                    st_nx = HALTED;
                end else if (!stay) begin
                    st_nx = IDLE;
                end else if (tick) begin
                    accept = 1'b1;
                    if (st == STEP_PEND) begin
                        st_nx = IDLE;
                    end else if ((st == BURST) &&
                                 (rem == BURST_W'(1))) begin
                        st_nx = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.iMode != MODE_BURST) st_nx = IDLE;
            end
            HALTED: begin
                if ((bus.iMode == MODE_HALT) && !halt_s) begin
                    st_nx = IDLE;
                end
            end
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            st     <= IDLE;
            rem    <= '0;
            clk_en <= 1'b0;
            pcnt   <= '0;
        end else begin
            st     <= st_nx;
            clk_en <= accept;
            if (accept) pcnt <= pcnt + CNT_W'(1);
            if (load) begin
                rem <= bus.iBurstLen;
            end else if ((st == BURST) && accept) begin
                rem <= rem - BURST_W'(1);
            end else if (st != BURST) begin
                rem <= '0;
            end
        end
    end

    assign bus.oClkEn    = clk_en;
    assign bus.oPulseCnt = pcnt;
    assign bus.oBusy     = active;
    assign bus.oHalted   = (st == HALTED);

endmodule

// File: tb/tb_clk_run_ctrl.sv
// Bench for clk_run_ctrl: directed table, corner sequences, random run.
// Every cycle is compared against a behavioural run-control model.
module tb_clk_run_ctrl;
    import clk_run_pkg::*;

`ifdef CLK_RUN_CTRL_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic iClk = 1'b0;
    logic nRst = 1'b0;
    always #5 iClk = ~iClk;

    clk_run_ctrl_if bus ();

    clk_run_ctrl dut (
        .iClk (iClk),
        .nRst (nRst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // model: kind 0 none, 1 run, 2 step, 3 burst
    int          m_kind;
    int          m_age;
    int          m_left;
    bit          m_halted;
    bit          m_done;
    bit          m_pulse;
    bit          m_prev_s;
    logic [31:0] m_total;
    bit          sp1, sp2, hp1, hp2;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] div;
        logic [15:0] len;
        logic        halt;
        int          n;
        int          pulses;
        logic        busy;
        logic        halted;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_kind   = 0;
        m_age    = 0;
        m_left   = 0;
        m_halted = 0;
        m_done   = 0;
        m_pulse  = 0;
        m_prev_s = 0;
        m_total  = '0;
        sp1 = 0; sp2 = 0; hp1 = 0; hp2 = 0;
    endtask

    task automatic model_edge();
        bit s, h, edge_s, want, fire;
        longint deff;
`ifdef CLK_RUN_CTRL_SYNC_EN
        s = sp2; h = hp2;
        sp2 = sp1; sp1 = bus.iStep;
        hp2 = hp1; hp1 = bus.iHalt;
`else
        s = bus.iStep; h = bus.iHalt;
`endif
        edge_s   = s && !m_prev_s;
        m_prev_s = s;
        deff     = (bus.iDiv == 0) ? 1 : longint'(bus.iDiv);
        m_pulse  = 0;
        if (m_kind != 0) begin
            want = (m_kind == 1 && bus.iMode == MODE_RUN)  ||
                   (m_kind == 2 && bus.iMode == MODE_STEP) ||
                   (m_kind == 3 && bus.iMode == MODE_BURST);
            fire = (longint'(m_age) + 1) >= deff;
            if (h) begin
                m_kind   = 0;
                m_halted = 1;
            end else if (!want) begin
                m_kind = 0;
            end else if (fire) begin
                m_pulse = 1;
                m_age   = 0;
                if (m_kind == 2) m_kind = 0;
                if (m_kind == 3) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_kind = 0;
                        m_done = 1;
                    end
                end
            end else begin
                m_age++;
            end
            if (m_kind == 0) m_age = 0;
        end else if (m_halted) begin
            if (bus.iMode == MODE_HALT && !h) m_halted = 0;
        end else if (m_done) begin
            if (bus.iMode != MODE_BURST) m_done = 0;
        end else begin
            m_age = 0;
            case (bus.iMode)
                MODE_RUN:  m_kind = 1;
                MODE_STEP: if (edge_s) m_kind = 2;
                MODE_BURST: begin
                    if (bus.iBurstLen == 0) begin
                        m_done = 1;
                    end else begin
                        m_kind = 3;
                        m_left = int'(bus.iBurstLen);
                    end
                end
                default: ;
            endcase
        end
        if (m_pulse) m_total = m_total + 32'd1;
    endtask

    task automatic cyc(input int n);
        logic [63:0] got, exp;
        for (int i = 0; i < n; i++) begin
            @(posedge iClk);
            if (nRst) model_edge();
            else model_reset();
            @(negedge iClk);
            got = {29'd0, bus.oClkEn, bus.oBusy,
                   bus.oHalted, bus.oPulseCnt};
            exp = {29'd0, m_pulse, (m_kind != 0),
                   m_halted, m_total};
            check("cycle", got, exp);
            if (bus.oClkEn) pulses++;
        end
    endtask

    task automatic do_reset();
        logic [63:0] got;
        bus.iMode = MODE_HALT;
        bus.iStep = 1'b0;
        bus.iHalt = 1'b0;
        nRst = 1'b0;
        model_reset();
        #1;
        got = {29'd0, bus.oClkEn, bus.oBusy,
               bus.oHalted, bus.oPulseCnt};
        check("reset_outputs", got, 64'd0);
        cyc(2);
        nRst = 1'b1;
    endtask

    initial begin
        bus.iMode     = MODE_HALT;
        bus.iStep     = 1'b0;
        bus.iDiv      = 32'd1;
        bus.iBurstLen = 16'd0;
        bus.iHalt     = 1'b0;
        model_reset();

        tbl[0] = '{MODE_RUN,   32'd4, 16'd0, 1'b0, 20, 4, 1'b1, 1'b0};
        tbl[1] = '{MODE_BURST, 32'd2, 16'd5, 1'b0, 20, 5, 1'b0, 1'b0};
        tbl[2] = '{MODE_BURST, 32'd3, 16'd0, 1'b0, 10, 0, 1'b0, 1'b0};
        tbl[3] = '{MODE_RUN,   32'd0, 16'd0, 1'b0, 10, 9, 1'b1, 1'b0};
        tbl[4] = '{MODE_RUN,   32'd1, 16'd0, 1'b0, 10, 9, 1'b1, 1'b0};
        tbl[5] = '{MODE_HALT,  32'd1, 16'd0, 1'b0, 10, 0, 1'b0, 1'b0};
        tbl[6] = '{MODE_STEP,  32'd3, 16'd0, 1'b0, 10, 0, 1'b0, 1'b0};
        tbl[7] = '{MODE_RUN,   32'd7, 16'd0, 1'b0, 14, 1, 1'b1, 1'b0};

        cyc(2);
        nRst = 1'b1;

        for (int v = 0; v < 8; v++) begin
            do_reset();
            bus.iMode     = tbl[v].mode;
            bus.iDiv      = tbl[v].div;
            bus.iBurstLen = tbl[v].len;
            bus.iHalt     = tbl[v].halt;
            pulses = 0;
            cyc(tbl[v].n);
            check($sformatf("vec%0d_pulses", v),
                  64'(pulses), 64'(tbl[v].pulses));
            check($sformatf("vec%0d_cnt", v),
                  64'(bus.oPulseCnt), 64'(tbl[v].pulses));
            check($sformatf("vec%0d_busy", v),
                  64'(bus.oBusy), 64'(tbl[v].busy));
            check($sformatf("vec%0d_halted", v),
                  64'(bus.oHalted), 64'(tbl[v].halted));
        end

        // halt held from the start: entered RUN then halted
        do_reset();
        bus.iMode = MODE_RUN;
        bus.iDiv  = 32'd3;
        bus.iHalt = 1'b1;
        pulses = 0;
        cyc(10);
        check("halt_start_pulses", 64'(pulses), 64'd0);
        check("halt_start_halted", 64'(bus.oHalted), 64'd1);
        bus.iHalt = 1'b0;
        bus.iMode = MODE_HALT;
        cyc(1 + LAT);

        // step: second edge while pending is dropped
        do_reset();
        bus.iMode = MODE_STEP;
        bus.iDiv  = 32'd3;
        cyc(2);
        pulses = 0;
        bus.iStep = 1'b1; cyc(1);
        bus.iStep = 1'b0; cyc(1);
        bus.iStep = 1'b1; cyc(1);
        bus.iStep = 1'b0; cyc(8);
        check("step_first_pulses", 64'(pulses), 64'd1);
        pulses = 0;
        bus.iStep = 1'b1; cyc(1);
        bus.iStep = 1'b0; cyc(8);
        check("step_second_pulses", 64'(pulses), 64'd1);
        check("step_cnt", 64'(bus.oPulseCnt), 64'd2);

        // halt mid-run, operator acknowledge via HALT mode
        do_reset();
        bus.iMode = MODE_RUN;
        bus.iDiv  = 32'd1;
        cyc(5);
        bus.iHalt = 1'b1;
        cyc(1 + LAT);
        pulses = 0;
        cyc(5);
        check("halt_pulses", 64'(pulses), 64'd0);
        check("halt_flag", 64'(bus.oHalted), 64'd1);
        bus.iHalt = 1'b0;
        cyc(3 + LAT);
        check("halt_run_stays", 64'(bus.oHalted), 64'd1);
        bus.iMode = MODE_HALT;
        cyc(1);
        check("halt_ack", 64'(bus.oHalted), 64'd0);
        check("halt_ack_busy", 64'(bus.oBusy), 64'd0);

        // async reset in the middle of a div-0 run
        do_reset();
        bus.iMode = MODE_RUN;
        bus.iDiv  = 32'd0;
        cyc(6);
        check("pre_reset_cnt", 64'(bus.oPulseCnt), 64'd5);
        do_reset();
        bus.iMode = MODE_RUN;
        cyc(1);
        pulses = 0;
        cyc(3);
        check("post_reset_pulses", 64'(pulses), 64'd3);
        check("post_reset_cnt", 64'(bus.oPulseCnt), 64'd3);

        // random operator activity against the model
        do_reset();
        for (int r = 0; r < 400; r++) begin
            bus.iMode     = 2'($urandom_range(0, 3));
            bus.iDiv      = 32'($urandom_range(0, 4));
            bus.iBurstLen = 16'($urandom_range(0, 4));
            bus.iHalt     = ($urandom_range(0, 11) == 0);
            bus.iStep     = 1'($urandom_range(0, 1));
            cyc($urandom_range(1, 6));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_run_ctrl.md
Name: clk_run_ctrl

Overview:
- Run-control sequencer for the processor clock enable.
- Derives a divided tick from iClk and gates it according to a selected mode: halt, free-run, single-step, or N-step burst.
- Sits between the board buttons/switches and the CPU core's clock-enable input.
- Emits one-iClk-wide enable pulses, not a derived clock, so the core stays on iClk.

Parameters:
- DIV_W, 32, width of divisor input and internal divide counter.
- BURST_W, 16, width of burst-length input and remaining-pulse counter.
- CNT_W, 32, width of issued-pulse counter output.

Ports:
- iClk  in  1  system clock
- nRst  in  1  asynchronous active-low reset
- iMode  in  2  00 HALT, 01 RUN, 10 STEP, 11 BURST
- iStep  in  1  step request; rising edge = one step
- iDiv  in  DIV_W  iClk cycles per tick; 0 treated as 1
- iBurstLen  in  BURST_W  pulses per burst
- iHalt  in  1  CPU halt indication (level)
- oClkEn  out  1  one-cycle CPU clock-enable pulse
- oBusy  out  1  high in RUN, STEP_PEND, BURST
- oHalted  out  1  high in HALTED
- oPulseCnt  out  CNT_W  total pulses issued, wraps at 2^CNT_W

Behaviour:
- Reset: nRst, asynchronous, active-low; clock iClk.
  - State IDLE; divide counter, remaining counter and step edge register = 0.
  - oClkEn = 0, oBusy = 0, oHalted = 0, oPulseCnt = 0.
- Divider:
  - div_eff = (iDiv == 0) ? 1 : iDiv, sampled every cycle.
  - Counter held at 0 outside active states (RUN, STEP_PEND, BURST).
  - In active states, increment each cycle; tick when count == div_eff-1, then count <= 0.
  - If iDiv is lowered below the current count, tick immediately and clear the counter (use the >= compare).
  - The first tick occurs div_eff cycles after entering an active state.
- oClkEn:
  - Registered; high for exactly one cycle, in the cycle after an internal tick that is accepted.
  - A tick is accepted only if the state is active and neither iHalt nor a mode-exit is present that cycle.
  - oPulseCnt increments with each oClkEn.
- Step edge: step_edge = iStep & ~iStep_q, where iStep_q is registered every cycle.
- Transitions, evaluated each cycle in priority order:
  - Any active state with iHalt = 1 -> HALTED. The tick in that cycle is suppressed.
  - IDLE:
    - mode RUN -> RUN.
    - mode STEP with step_edge -> STEP_PEND.
    - mode BURST -> BURST with remaining <= iBurstLen; if iBurstLen == 0, go directly to DONE.
    - mode HALT -> stay.
  - RUN: on tick, emit a pulse. If mode != RUN -> IDLE (tick suppressed).
  - STEP_PEND:
    - on tick, emit a pulse -> IDLE.
    - further step edges are ignored (not queued).
    - mode != STEP -> IDLE, no pulse.
  - BURST:
    - on tick, emit a pulse and remaining--.
    - at the tick where remaining == 1 -> DONE.
    - mode != BURST -> IDLE; remaining is discarded.
  - DONE:
    - waits for mode != BURST -> IDLE, so one selection gives one burst.
    - iHalt is ignored here.
  - HALTED:
    - oHalted = 1.
    - -> IDLE only when iMode == HALT and iHalt == 0 (operator acknowledge).
- oBusy and oHalted are decoded from the registered state.

Optional Feature:
- Macro: CLK_RUN_CTRL_SYNC_EN.
- Defined:
  - iStep and iHalt each pass through a 2-flop synchronizer (reset 0) before use.
  - This adds 2 cycles of latency to step-edge and halt response.
- Undefined:
  - Inputs are used directly; the caller guarantees they are synchronous to iClk.

Decomposition:
- Package clk_run_pkg:
  - mode encodings MODE_HALT, MODE_RUN, MODE_STEP, MODE_BURST.
  - state enum IDLE, RUN, STEP_PEND, BURST, DONE, HALTED.
- Sub-module tick_gen:
  - DIV_W counter with enable, clear and div_eff handling.
  - Outputs a single-cycle tick.

Test Plan:
- RUN, iDiv=4, hold for 20 cycles -> oClkEn every 4th cycle, first at cycle 5 after mode set; oPulseCnt = 4 or 5 (check exact edge).
- STEP, iDiv=3:
  - two iStep rising edges 1 cycle apart -> exactly one pulse, ~3 cycles after the first edge.
  - a later edge -> a second pulse.
- BURST, iBurstLen=5, iDiv=2 -> exactly 5 pulses, 2 cycles apart, then DONE with no pulses.
- BURST, iBurstLen=0 -> zero pulses.
- RUN, iDiv=1, assert iHalt mid-run -> no pulse from the halt cycle on, oHalted=1.
  - Dropping iHalt with mode RUN stays HALTED.
  - Mode HALT returns to IDLE.
- RUN with iDiv=0 -> pulse every cycle.
  - Drop nRst mid-run -> all outputs 0 immediately, oPulseCnt=0.
  - Release -> restart from IDLE.
